// File: rtl/powlib_sfifo.sv
// ---------------------------------------------------------------------------
// powlib_sfifo
//   Single-clock show-ahead FIFO with registered flow-control flags.
//
//   Parameters
//     W    data width in bits
//     D    depth in words (power of two, >= 2)
//     AFT  almost-full threshold in words (1..D)
//     CW   count width, $clog2(D)+1 (derived, not overridable)
//
//   Ports
//     clk     clock, all state changes on the rising edge
//     rst     asynchronous active-low reset
//     wrdata  write data
//     wrvld   write data valid
//     wrrdy   FIFO can accept a write (count < D)
//     rddata  head-of-FIFO word (valid while rdvld=1)
//     rdvld   FIFO holds at least one word
//     rdrdy   consumer accepts rddata
//     count   number of stored words, 0..D
//     af      almost full, registered (count >= AFT)
// ---------------------------------------------------------------------------
module powlib_sfifo #(
  parameter  int unsigned W   = 16,
  parameter  int unsigned D   = 8,
  parameter  int unsigned AFT = 6,
  localparam int unsigned CW  = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  output logic [CW-1:0] count,
  output logic          af
);

  localparam int unsigned   AW      = $clog2(D);
  localparam logic [CW-1:0] C_DEPTH = CW'(D);
  localparam logic [CW-1:0] C_AFT   = CW'(AFT);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] C_PINC  = AW'(1);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_af;

  logic          w_wrrdy;
  logic          w_rdvld;
  logic          w_wr;
  logic          w_rd;
  logic [CW-1:0] w_count_nxt;

  // Flags decode only registered count, so there is no combinational
  // path from wrvld/rdrdy to either handshake output.  When full, wrrdy
  // is low regardless of a concurrent read.
  assign w_wrrdy = (r_count < C_DEPTH);
  assign w_rdvld = (r_count != '0);

  assign w_wr = wrvld & w_wrrdy;
  assign w_rd = rdrdy & w_rdvld;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_rd && !w_wr) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  // Pointers, count and af are reset; D is a power of two so the
  // pointers wrap naturally at D-1 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_af    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + C_PINC;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + C_PINC;
      end
      r_count <= w_count_nxt;
      r_af    <= (w_count_nxt >= C_AFT);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= wrdata;
    end
  end

  assign wrrdy  = w_wrrdy;
  assign rdvld  = w_rdvld;
  assign rddata = r_mem[r_rptr];
  assign count  = r_count;
  assign af     = r_af;

endmodule
